// File: rtl/shift_add_multiplier_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_ctrl_if
//   Request/response bundle for the sequential shift-add multiplier.
//   Signals:
//     start         requester -> multiplier : request, sampled only while idle
//     multiplicand  requester -> multiplier : operand M (N bits)
//     multiplier    requester -> multiplier : operand Q (N bits)
//     busy          multiplier -> requester : high whenever an operation is active
//     done          multiplier -> requester : one-cycle pulse, product is new
//     product       multiplier -> requester : registered 2N-bit result
//   Modports: master (requester side), slave (multiplier side).
// -----------------------------------------------------------------------------
interface shift_add_multiplier_ctrl_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier_ctrl.sv
// -----------------------------------------------------------------------------
// N_bit_adder
//   Plain N-bit ripple-carry adder, no carry-in and no carry-out port.
//   Ports:
//     a, b  input  N : addends
//     sum   output N : a + b modulo 2^N
// -----------------------------------------------------------------------------
module N_bit_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    // carry[i] is the carry into bit i; the carry out of the MSB is dropped.
    logic [N-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

// -----------------------------------------------------------------------------
// shift_add_multiplier_ctrl
//   Sequential unsigned N x N multiplier. One shared (N+1)-bit ripple adder is
//   stepped through N add-and-shift iterations, one per clock, giving a fixed
//   latency of N edges from acceptance to the done pulse and one result every
//   N+2 cycles when start is held high.
//   Ports:
//     clk  input  : rising-edge clock
//     rst  input  : asynchronous active-high reset, clears control and data
//     bus  slave  : start/multiplicand/multiplier in, busy/done/product out
// -----------------------------------------------------------------------------
module shift_add_multiplier_ctrl #(
    parameter int N = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    shift_add_multiplier_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             busy_q, done_q;
    logic             busy_n, done_n;
    logic             load, step, last;

    logic [N-1:0]     m_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     q_q;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   product_q;

    logic [N:0]       add_a, add_b, sum;

    // The adder is one bit wider than the operands so that bit N of the sum
    // carries the carry-out; that bit becomes the MSB of A after the shift.
    // Selecting zero for the second addend when Q[0]=0 makes sum = {0,A}.
    assign add_a = {1'b0, a_q};
    assign add_b = q_q[0] ? {1'b0, m_q} : '0;

    N_bit_adder #(
        .N (N + 1)
    ) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (sum)
    );

    // State and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(N - 1)) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // Operand, accumulator, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            if (load) begin
                m_q <= bus.multiplicand;
                q_q <= bus.multiplier;
                a_q <= '0;
                cnt <= '0;
            end else if (step) begin
                // {C,A,Q} <= {sum,Q} >> 1; the carry register always shifts
                // back to zero, so only A and Q need storage.
                a_q <= sum[N:1];
                q_q <= {sum[0], q_q[N-1:1]};
                cnt <= cnt + CNT_W'(1);
            end
            if (last) begin
                product_q <= {sum, q_q[N-1:1]};
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
module tb_shift_add_multiplier_ctrl;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    shift_add_multiplier_ctrl_if #(.N(N)) bus ();

    shift_add_multiplier_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands with start high and step past the sampling edge (E0).
    task automatic accept(input logic [N-1:0] m, input logic [N-1:0] q);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Advance until done is seen; edges = number of edges taken, -1 on timeout.
    task automatic wait_done(output int edges, output logic [2*N-1:0] prod);
        edges = -1;
        prod  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                edges = i;
                prod  = bus.product;
                break;
            end
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 00000000",
                     bus.busy, bus.done, bus.product);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int               e;
        logic [2*N-1:0]   p;
        accept(16'd3, 16'd5);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy_rise: busy=%b want 1", bus.busy);
        end
        wait_done(e, p);
        n_cmp++;
        if (e !== 16) begin
            n_bad++;
            $display("FAIL basic_latency: edges=%0d want 16", e);
        end
        n_cmp++;
        if (p !== 32'h0000000F) begin
            n_bad++;
            $display("FAIL basic_product: got %h want 0000000F", p);
        end
        step_cycle();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_return_idle: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_carry();
        int               e;
        logic [2*N-1:0]   p;
        accept(16'hFFFF, 16'hFFFF);
        wait_done(e, p);
        n_cmp++;
        if (e !== 16 || p !== 32'hFFFE0001) begin
            n_bad++;
            $display("FAIL carry_ffff_ffff: edges=%0d product=%h want 16 FFFE0001", e, p);
        end
        step_cycle();
        accept(16'hFFFF, 16'h0001);
        wait_done(e, p);
        n_cmp++;
        if (e !== 16 || p !== 32'h0000FFFF) begin
            n_bad++;
            $display("FAIL carry_ffff_0001: edges=%0d product=%h want 16 0000FFFF", e, p);
        end
        step_cycle();
    endtask

    task automatic test_zero_hold();
        int               e;
        logic [2*N-1:0]   p;
        accept(16'h1234, 16'h0000);
        wait_done(e, p);
        n_cmp++;
        if (e !== 16 || p !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_product: edges=%0d product=%h want 16 00000000", e, p);
        end
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            n_cmp++;
            if (bus.product !== 32'h0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_hold_%0d: product=%h done=%b want 00000000 0",
                         i, bus.product, bus.done);
            end
        end
    endtask

    task automatic test_ignored_start();
        int               dones;
        int               e;
        logic [2*N-1:0]   p;
        logic [2*N-1:0]   first_p;
        dones   = 0;
        first_p = '0;
        accept(16'd7, 16'd9);
        repeat (4) step_cycle();
        // Sampled at E5, mid-calculation: must be ignored.
        bus.start        = 1'b1;
        bus.multiplicand = 16'hFFFF;
        bus.multiplier   = 16'hFFFF;
        step_cycle();
        bus.start = 1'b0;
        for (int i = 6; i <= 16; i++) begin
            step_cycle();
            if (bus.done === 1'b1) begin
                dones++;
                first_p = bus.product;
            end
        end
        n_cmp++;
        if (first_p !== 32'd63) begin
            n_bad++;
            $display("FAIL ignored_product: got %0d want 63", first_p);
        end
        // Now in the DONE cycle: start sampled at E17 must also be ignored.
        bus.start = 1'b1;
        step_cycle();
        if (bus.done === 1'b1) dones++;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_no_accept_e17: busy=%b want 0", bus.busy);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL ignored_done_count: pulses=%0d want 1", dones);
        end
        step_cycle();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ignored_accept_e18: busy=%b want 1", bus.busy);
        end
        wait_done(e, p);
        n_cmp++;
        if (e !== 16 || p !== 32'hFFFE0001) begin
            n_bad++;
            $display("FAIL ignored_followup: edges=%0d product=%h want 16 FFFE0001", e, p);
        end
        step_cycle();
    endtask

    task automatic test_back_to_back();
        int               e1, e2;
        logic [2*N-1:0]   p1, p2;
        bus.multiplicand = 16'd2;
        bus.multiplier   = 16'd3;
        bus.start        = 1'b1;
        step_cycle();
        bus.multiplicand = 16'd100;
        bus.multiplier   = 16'd200;
        wait_done(e1, p1);
        wait_done(e2, p2);
        bus.start = 1'b0;
        n_cmp++;
        if (e1 !== 16 || p1 !== 32'd6) begin
            n_bad++;
            $display("FAIL b2b_first: edges=%0d product=%0d want 16 6", e1, p1);
        end
        n_cmp++;
        if (e2 !== N + 2) begin
            n_bad++;
            $display("FAIL b2b_spacing: edges=%0d want %0d", e2, N + 2);
        end
        n_cmp++;
        if (p2 !== 32'd20000) begin
            n_bad++;
            $display("FAIL b2b_second: product=%0d want 20000", p2);
        end
        step_cycle();
        step_cycle();
    endtask

    task automatic test_reset_mid();
        int               dones;
        int               e;
        logic [2*N-1:0]   p;
        dones = 0;
        accept(16'hFFFF, 16'hFFFF);
        repeat (8) step_cycle();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_async: busy=%b done=%b product=%h want 0 0 00000000",
                     bus.busy, bus.done, bus.product);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step_cycle();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: active cycles=%0d want 0", dones);
        end
        accept(16'd12, 16'd11);
        wait_done(e, p);
        n_cmp++;
        if (e !== 16 || p !== 32'd132) begin
            n_bad++;
            $display("FAIL reset_mid_recover: edges=%0d product=%0d want 16 132", e, p);
        end
        step_cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero_hold();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier_ctrl.md
# shift_add_multiplier_ctrl

Sequential unsigned N×N multiplier that produces the 2N-bit product by sequencing one shared ripple-carry adder through N add-and-shift steps. It is the control and datapath layer on top of the team's `N_bit_adder`, and owns the operand and accumulator registers, the step counter and the start/done handshake. It is the block the rest of the design talks to whenever it needs a multiply. It spends one adder pass per multiplier bit, with a fixed latency and no early termination.

## Interface
- `N`, default 16: operand width. Legal range is N ≥ 2. The step counter is $clog2(N+1) bits wide.
- `clk`  input  1  the single clock. All state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request. Sampled only in IDLE.
- `multiplicand`  input  N  operand M. Captured on the accepting edge.
- `multiplier`  input  N  operand Q. Captured on the accepting edge.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `done`  output  1  one-cycle pulse that marks a valid new `product`.
- `product`  output  2N  registered result. Holds its value until the next completion.

## Operation
- **Datapath registers**
  - M: N bits.
  - A: accumulator, N bits, plus carry bit C.
  - Q: N bits.
  - cnt: step counter.
- **Adder instance**
  - Exactly one `N_bit_adder`, instantiated with parameter N+1.
  - Inputs are {1'b0, A} and {1'b0, M}. The (N+1)-bit sum supplies {C, A_next}.
  - `N_bit_adder` exposes no carry-out port. The widened instance is the mandated way to recover the carry.
- **States**
  - IDLE: `busy`=0, `done`=0.
    - If `start`=1: load M←multiplicand, Q←multiplier, A←0, C←0, cnt←0, and go to CALC.
    - Otherwise stay in IDLE.
  - CALC: one step per cycle.
    - sum = Q[0] ? {0,A}+{0,M} : {0,A}.
    - {C,A,Q} ← {sum, Q} >> 1. The shifted-in MSB is sum[N].
    - cnt←cnt+1.
    - When cnt==N-1: `product` ← the shifted {A,Q} (2N bits), `done`←1, go to DONE.
  - DONE: `done`=1 for exactly this one cycle, then go unconditionally to IDLE.
- **Start handling**
  - `start` is ignored in CALC and in DONE. No queuing, no error indication.
  - Holding `start` high permanently yields back-to-back operations, one per N+2 cycles.
- **Operand handling**
  - Operand inputs are don't-care after the accepting edge. Changing them mid-operation has no effect.
- **Arithmetic**
  - Unsigned only.
  - The result is exact for all 2^2N operand pairs. No overflow is possible, since the product fits in 2N bits.
- **Reset**
  - `rst`=1 at any time, including mid-CALC or in DONE, immediately forces the following. No completion pulse is emitted for an aborted operation.
    - state←IDLE
    - `busy`=0, `done`=0
    - `product`=0, A=0, C=0, Q=0, M=0, cnt=0
- **Reset values of outputs:** `busy`=0, `done`=0, `product`=0.

## Timing
- **Edge numbering:** accepting edge is E0 (IDLE, `start`=1).
- **After E0:** CALC, `busy`=1.
- **Edges E1..EN:** perform steps 1..N.
- **EN (last step):** loads `product` and raises `done`. The FSM enters DONE.
- **E(N+1):** returns to IDLE. `done` and `busy` drop.
- **Latency:** `done` is visible N edges after acceptance (16 for the default).
- **Throughput:** the earliest next accept is E(N+2), so one result per N+2 cycles.
- **Output registration:** `busy`, `done` and `product` are registered. There is no combinational path from inputs to outputs.
- **Critical path:** one (N+1)-bit ripple through the shared adder plus a 2:1 mux per cycle.

## Test plan
- **Basic multiply.** N=16, M=3, Q=5, 1-cycle `start` at E0.
  - `busy` rises after E0.
  - `done`=1 only in the cycle after E16, with `product`=0x0000000F.
  - `busy`=0 after E17.
- **Carry path.** M=0xFFFF, Q=0xFFFF.
  - `product`=0xFFFE0001, confirming C propagation through the widened adder.
  - Then M=0xFFFF, Q=0x0001 gives `product`=0x0000FFFF.
- **Zero and hold.**
  - M=0x1234, Q=0 gives `product`=0.
  - `product` then holds 0 through 20 idle cycles with `start`=0.
- **Ignored start and operand change.** Accept M=7, Q=9.
  - Pulse `start` and change operands to 0xFFFF at E5 and in the DONE cycle.
  - Exactly one `done` pulse, `product`=63.
  - The next accept occurs no earlier than E18.
- **Back-to-back.** `start` held high with operand pairs (2,3), then (100,200).
  - `done` pulses N+2 cycles apart.
  - Products are 6, then 20000.
- **Reset mid-operation.** Assert `rst` asynchronously at the midpoint of CALC (after E8).
  - Immediately `busy`=0, `done`=0, `product`=0.
  - No `done` pulse follows.
  - After deassertion, 12×11 completes with `product`=132 and standard latency.
